// File: rtl/key_event.sv
// key_event
//
// Turns the debounced key level into single-cycle event strobes for
// downstream logic: press, release, long-press and auto-repeat, plus a
// "held" level. All timing is in clk cycles and every output is registered.
//
// Parameters
//   ACTIVE_LOW : 1 -> keyin==0 means pressed, 0 -> keyin==1 means pressed
//   LONG_TH    : cycles from press to the long_press strobe (2..2^32-1)
//   REPEAT_TH  : cycles between repeat_pulse strobes after long-press (2..2^32-1)
//   REPEAT_EN  : 1 enables auto-repeat after long-press
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   synchronous active-low reset
//   keyin         in   debounced key level, synchronous to clk
//   press         out  one-cycle strobe when the key goes down
//   release_pulse out  one-cycle strobe when the key goes up
//   long_press    out  one-cycle strobe when the hold reaches LONG_TH
//   repeat_pulse  out  one-cycle strobe every REPEAT_TH cycles after long-press
//   held          out  high while the key is considered pressed

module key_event #(
    parameter logic        ACTIVE_LOW = 1'b1,
    parameter logic [31:0] LONG_TH    = 32'd50000000,
    parameter logic [31:0] REPEAT_TH  = 32'd10000000,
    parameter logic        REPEAT_EN  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic keyin,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic        pk;

    // Normalise polarity so the state machine only ever sees "pressed".
    assign pk = keyin ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Reset aborts any hold silently: no release strobe is produced.
            state         <= IDLE;
            cnt           <= 32'd0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            // Strobes are cleared every edge unless set below, so each is one cycle wide.
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    if (pk) begin
                        state <= HOLD;
                        cnt   <= 32'd0;
                        press <= 1'b1;
                        held  <= 1'b1;
                    end else begin
                        held  <= 1'b0;
                    end
                end

                HOLD: begin
                    // Release is tested first so it wins over a coincident threshold.
                    if (!pk) begin
                        state         <= IDLE;
                        cnt           <= 32'd0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (cnt == LONG_TH - 32'd1) begin
                        state      <= RPT;
                        cnt        <= 32'd0;
                        long_press <= 1'b1;
                        held       <= 1'b1;
                    end else begin
                        cnt  <= cnt + 32'd1;
                        held <= 1'b1;
                    end
                end

                RPT: begin
                    if (!pk) begin
                        state         <= IDLE;
                        cnt           <= 32'd0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (REPEAT_EN && (cnt == REPEAT_TH - 32'd1)) begin
                        cnt          <= 32'd0;
                        repeat_pulse <= 1'b1;
                        held         <= 1'b1;
                    end else begin
                        // With repeat disabled the counter is frozen while held.
                        if (REPEAT_EN) begin
                            cnt <= cnt + 32'd1;
                        end
                        held <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= 32'd0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event.sv
// Testbench for key_event. Instance u0 uses LONG_TH=8, REPEAT_TH=4,
// ACTIVE_LOW=1, REPEAT_EN=1 and is driven from a vector table; instance u1
// uses ACTIVE_LOW=0, REPEAT_EN=0 and is driven by a hand-written sequence.
// Expected outputs are packed as {press, release, long_press, repeat_pulse, held}.

module tb_key_event;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, keyin;
    logic press0, rel0, long0, rpt0, held0;
    logic rst1_n, keyin1;
    logic press1, rel1, long1, rpt1, held1;

    key_event #(
        .ACTIVE_LOW(1'b1), .LONG_TH(32'd8), .REPEAT_TH(32'd4), .REPEAT_EN(1'b1)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .keyin(keyin),
        .press(press0), .release_pulse(rel0), .long_press(long0),
        .repeat_pulse(rpt0), .held(held0)
    );

    key_event #(
        .ACTIVE_LOW(1'b0), .LONG_TH(32'd8), .REPEAT_TH(32'd4), .REPEAT_EN(1'b0)
    ) u1 (
        .clk(clk), .rst_n(rst1_n), .keyin(keyin1),
        .press(press1), .release_pulse(rel1), .long_press(long1),
        .repeat_pulse(rpt1), .held(held1)
    );

    typedef struct {
        string      tag;
        logic       rst;
        logic       key;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(string t, logic r, logic k,
                                logic p, logic rl, logic l, logic rp, logic h);
        vec_t v;
        v.tag = t;
        v.rst = r;
        v.key = k;
        v.exp = {p, rl, l, rp, h};
        vecs.push_back(v);
    endfunction

    task automatic check(string t, int idx, logic [4:0] got, logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got {press,release,long,repeat,held}=%b want %b",
                     t, idx, got, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        keyin  = 1'b1;
        rst1_n = 1'b0;
        keyin1 = 1'b0;

        // Reset with key up, then 20 quiet cycles.
        for (int i = 0; i < 3; i++)  add("reset", 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) add("quiet", 1, 1, 0, 0, 0, 0, 0);

        // Short press: 5 low samples, then release.
        for (int i = 0; i < 5; i++)  add("short", 1, 0, i == 0, 0, 0, 0, 1);
        add("short_rel", 1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++)  add("idle", 1, 1, 0, 0, 0, 0, 0);

        // Long hold: long at +8, repeats at +12, +16, ... +28.
        for (int i = 0; i < 30; i++)
            add("long", 1, 0, i == 0, 0, i == 8, (i >= 12) && (i % 4 == 0), 1);
        add("long_rel", 1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++)  add("idle", 1, 1, 0, 0, 0, 0, 0);

        // Release exactly at the long-press boundary: release wins.
        for (int i = 0; i < 8; i++)  add("edge_long", 1, 0, i == 0, 0, 0, 0, 1);
        add("edge_long_rel", 1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++)  add("idle", 1, 1, 0, 0, 0, 0, 0);

        // Release exactly at the first repeat boundary: release wins.
        for (int i = 0; i < 12; i++) add("edge_rpt", 1, 0, i == 0, 0, i == 8, 0, 1);
        add("edge_rpt_rel", 1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++)  add("idle", 1, 1, 0, 0, 0, 0, 0);

        // Reset mid-hold: clears silently, press re-fires, long 8 later.
        for (int i = 0; i < 10; i++) add("midrst_a", 1, 0, i == 0, 0, i == 8, 0, 1);
        add("midrst", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add("midrst_b", 1, 0, i == 0, 0, i == 8, 0, 1);
        add("midrst_rel", 1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++)  add("idle", 1, 1, 0, 0, 0, 0, 0);

        // One-cycle press, then immediate re-press with a fresh count.
        add("tap", 1, 0, 1, 0, 0, 0, 1);
        add("tap_rel", 1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++)  add("repress", 1, 0, i == 0, 0, i == 8, 0, 1);
        add("repress_rel", 1, 1, 0, 1, 0, 0, 0);
        add("idle", 1, 1, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst;
            keyin = vecs[i].key;
            @(posedge clk);
            #1;
            check(vecs[i].tag, i, {press0, rel0, long0, rpt0, held0}, vecs[i].exp);
        end

        // u1: active-high key, repeat disabled.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("u1_reset", i, {press1, rel1, long1, rpt1, held1}, 5'b00000);
        end
        rst1_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("u1_idle", i, {press1, rel1, long1, rpt1, held1}, 5'b00000);
        end
        keyin1 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [4:0] e;
            e = {i == 0, 1'b0, i == 8, 1'b0, 1'b1};
            @(posedge clk);
            #1;
            check("u1_hold", i, {press1, rel1, long1, rpt1, held1}, e);
        end
        keyin1 = 1'b0;
        @(posedge clk);
        #1;
        check("u1_rel", 0, {press1, rel1, long1, rpt1, held1}, 5'b01000);
        @(posedge clk);
        #1;
        check("u1_after", 0, {press1, rel1, long1, rpt1, held1}, 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/key_event.md
# key_event

Key event decoder that consumes the clean level produced by the key debouncer and turns it into single-cycle event pulses for downstream logic such as the seven-segment display controller and counters. It emits press, release, long-press and auto-repeat strobes, plus a held level. All timing is counted in `clk` cycles, and every output is registered.

## Interface
Parameters:
- `ACTIVE_LOW`, default 1: 1 means `keyin`==0 is "pressed"; 0 means `keyin`==1 is "pressed".
- `LONG_TH`, default 50000000: cycles from press to long-press (1 s at 50 MHz); legal range 2..2^32-1.
- `REPEAT_TH`, default 10000000: cycles between auto-repeat strobes (200 ms at 50 MHz); legal range 2..2^32-1.
- `REPEAT_EN`, default 1: 1 enables auto-repeat after long-press; 0 disables it.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `keyin`  in  1  debounced key level, synchronous to `clk`.
- `press`  out  1  one-cycle strobe on press.
- `release`  out  1  one-cycle strobe on release.
- `long_press`  out  1  one-cycle strobe when the hold reaches `LONG_TH`.
- `repeat_pulse`  out  1  one-cycle strobe every `REPEAT_TH` cycles after long-press.
- `held`  out  1  level; high while the key is considered pressed.

## Operation
- Internal pressed term: `pk = keyin ^ ACTIVE_LOW`.
- 32-bit counter `cnt`, unsigned; it never wraps because it is cleared at each threshold.
- States:
  - IDLE: key released.
  - HOLD: pressed, before long-press.
  - RPT: pressed, at or after long-press.
- Transitions, evaluated at each edge with `rst_n`=1:
  - IDLE & `pk`: go to HOLD, `cnt`<=0, `press`<=1.
  - IDLE & !`pk`: stay in IDLE.
  - HOLD & !`pk`: go to IDLE, `cnt`<=0, `release`<=1.
  - HOLD & `pk` & `cnt`==`LONG_TH`-1: go to RPT, `cnt`<=0, `long_press`<=1.
  - HOLD & `pk` otherwise: `cnt`<=`cnt`+1.
  - RPT & !`pk`: go to IDLE, `cnt`<=0, `release`<=1.
  - RPT & `pk` & `REPEAT_EN` & `cnt`==`REPEAT_TH`-1: `cnt`<=0, `repeat_pulse`<=1.
  - RPT & `pk` otherwise: `cnt`<=`cnt`+1 if `REPEAT_EN`; `cnt` holds if !`REPEAT_EN`.
- Strobes default to 0 on every edge where they are not set above, so each strobe is exactly one cycle wide.
- `held` <= 1 when the next state is HOLD or RPT; 0 when it is IDLE.
- Simultaneous events: release takes priority. If `pk` drops on the same edge a threshold is reached, only `release` fires; no `long_press` or `repeat_pulse` is emitted.
- At most one strobe is high in any cycle.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `cnt`=0, and `press`, `release`, `long_press`, `repeat_pulse`, `held` all 0.
- Reset mid-hold aborts the hold with no `release` strobe.
- If the key is still pressed when `rst_n` rises, `press` fires at the first edge with `rst_n`=1.
- Latency from `keyin` sampled pressed at edge E:
  - `press` and `held` are high after E; `press` drops after E+1.
- `long_press` is high after edge E+`LONG_TH`, i.e. `LONG_TH` cycles after `press`.
- `repeat_pulse` fires at E+`LONG_TH`+k·`REPEAT_TH`, for k≥1.
- Release sampled at edge R: `release` is high after R and `held` is 0 after R.
- A press of 1 cycle is legal: `press` at E, then `release` at E+1, back-to-back.
- Re-press immediately after release restarts from IDLE with `cnt`=0.

## Test plan
Parameters for the bench: `LONG_TH`=8, `REPEAT_TH`=4, `ACTIVE_LOW`=1, unless stated otherwise.
- Reset check: hold `rst_n`=0 for 3 cycles with `keyin`=1 -> all outputs 0. Release reset with `keyin`=1 -> no strobes for 20 cycles.
- Short press: `keyin`=0 for 5 cycles, then 1 -> `press` 1 cycle after the first low sample, `held` high for 5 cycles, `release` 1 cycle after the first high sample, no `long_press`.
- Long hold with repeat: `keyin`=0 for 30 cycles -> `press` at t0, `long_press` at t0+8, `repeat_pulse` at t0+12, t0+16, t0+20, t0+24, t0+28, then `release` on the rising sample.
- Release at threshold: `keyin` returns high exactly at the edge where `cnt`==7 -> `release` only, `long_press` never asserts; same check at a repeat boundary.
- `REPEAT_EN`=0 and `ACTIVE_LOW`=0: `keyin`=1 for 30 cycles -> `press`, `long_press` at +8, no `repeat_pulse`, `release` on the drop.
- Reset mid-hold: `rst_n`=0 for 1 cycle at t0+10 while `keyin` stays low -> outputs clear with no `release`; `press` re-fires at the first edge after `rst_n`=1, and `long_press` follows 8 cycles later.
